receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver.sv | 111 +++++++++++
 tb/tb_receiver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// rtl/receiver.sv - frame receiver: collects msg+hash words, runs the hash engine, reports match/timeout
module receiver #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [2:0]    rx_bytenum,
  output logic [511:0]  hc_msg,
  output logic [2:0]    hc_bytenum,
  output logic          hc_in_ready,
  input  logic [1599:0] hc_hashcode,
  input  logic          hc_done,
  output logic [511:0]  msg_out,
  output logic          done,
  output logic          match,
  output logic          err
);

  localparam logic [2:0] RECV   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] CMP    = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [5:0]    word_cnt;
  logic [7:0]    wait_cnt;
  logic [2111:0] frame;
  logic [2:0]    bytenum_q;
  logic [1599:0] hash_q;
  logic [511:0]  msg_q;
  logic          match_q;
  logic          err_q;

  // Words shift in MSB-first, so after 33 words word k sits at [2111-64k -: 64].
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RECV;
      word_cnt  <= 6'd0;
      wait_cnt  <= 8'd0;
      frame     <= '0;
      bytenum_q <= 3'd0;
      hash_q    <= '0;
      msg_q     <= '0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          if (rx_valid) begin
            frame <= {frame[2047:0], rx_data};
            if (word_cnt == 6'd0) begin
              bytenum_q <= rx_bytenum;
            end
            if (word_cnt == 6'd32) begin
              word_cnt <= 6'd0;
              state    <= START;
            end else begin
              word_cnt <= word_cnt + 6'd1;
            end
          end
        end
        START: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (hc_done) begin
            hash_q <= hc_hashcode;
            state  <= CMP;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            match_q <= 1'b0;
            err_q   <= 1'b1;
            msg_q   <= frame[2111:1600];
            state   <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        CMP: begin
          match_q <= (hash_q == frame[1599:0]);
          err_q   <= 1'b0;
          msg_q   <= frame[2111:1600];
          state   <= REPORT;
        end
        REPORT: begin
          state <= RECV;
        end
        default: begin
          state <= RECV;
        end
      endcase
    end
  end

  // Outputs are forced low during reset so nothing stale leaks out before the first edge.
  assign rx_ready    = !reset && (state == RECV);
  assign hc_in_ready = !reset && (state == START);
  assign done        = !reset && (state == REPORT);
  assign match       = !reset && match_q;
  assign err         = !reset && err_q;
  assign hc_msg      = reset ? '0 : frame[2111:1600];
  assign hc_bytenum  = reset ? 3'd0 : bytenum_q;
  assign msg_out     = reset ? '0 : msg_q;

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - table-driven self-checking bench for receiver with a done scoreboard
module tb_receiver;

  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [2:0]    rx_bytenum;
  logic [511:0]  hc_msg;
  logic [2:0]    hc_bytenum;
  logic          hc_in_ready;
  logic [1599:0] hc_hashcode;
  logic          hc_done;
  logic [511:0]  msg_out;
  logic          done;
  logic          match;
  logic          err;

  receiver #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_bytenum(rx_bytenum),
    .hc_msg(hc_msg), .hc_bytenum(hc_bytenum), .hc_in_ready(hc_in_ready),
    .hc_hashcode(hc_hashcode), .hc_done(hc_done),
    .msg_out(msg_out), .done(done), .match(match), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] msg;
    int           flip;      // hash bit the engine corrupts, -1 = none
    int           gap;       // idle cycles between words
    logic [2:0]   bn;
    int           delay;     // hc_done this many cycles after hc_in_ready, -1 = never
    logic         exp_match;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic         match;
    logic         err;
    logic [511:0] msg;
    logic [2:0]   bn;
    int           done_cyc;
  } exp_t;

  exp_t          sb[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [1599:0] hv;
  logic [511:0]  base_msg;
  vec_t          vecs[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  initial begin
    logic ready_next;
    exp_t e;
    ready_next = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_next) begin
        chk("rx_ready_after_done", rx_ready, 1);
        ready_next = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("match", match, e.match);
          chk("err", err, e.err);
          chk("msg_out", msg_out, e.msg);
          chk("hc_bytenum", hc_bytenum, e.bn);
          chk("done_cycle", cyc, e.done_cyc);
          ready_next = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rx_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) begin
      $display("FAIL rx_ready_wait: got 0 expected 1");
      $fatal(1, "rx_ready never asserted");
    end
  endtask

  task automatic send_words(input logic [2111:0] f, input int n, input int gap,
                            input logic [2:0] bn0, output int last_cyc);
    last_cyc = 0;
    for (int k = 0; k < n; k++) begin
      rx_data    = f[2111 - 64*k -: 64];
      rx_bytenum = (k == 0) ? bn0 : 3'd3;
      rx_valid   = 1'b1;
      wait_ready();
      last_cyc = cyc;
      @(posedge clk); #1;
      if (gap > 0 && k < n - 1) begin
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      $display("FAIL done_wait: got 0 expected 1");
      $fatal(1, "done never asserted");
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [1599:0] h;
    exp_t e;
    int n_cyc;
    send_words({v.msg, hv}, 33, v.gap, v.bn, n_cyc);
    // sender keeps a word pending while the block is busy
    rx_data  = 64'hbad0_bad0_bad0_bad0;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("hc_in_ready", hc_in_ready, 1);
    chk("start_cycle", cyc, n_cyc + 1);
    chk("rx_ready_start", rx_ready, 0);
    chk("hc_msg", hc_msg, v.msg);
    chk("hc_bytenum_start", hc_bytenum, v.bn);
    e.match = v.exp_match;
    e.err   = v.exp_err;
    e.msg   = v.msg;
    e.bn    = v.bn;
    if (v.delay >= 1) begin
      repeat (v.delay) begin @(posedge clk); #1; end
      h = hv;
      if (v.flip >= 0) h[v.flip] = ~h[v.flip];
      hc_hashcode = h;
      hc_done     = 1'b1;
      e.done_cyc  = cyc + 2;
      sb.push_back(e);
      @(negedge clk);
      chk("rx_ready_wait", rx_ready, 0);
      @(posedge clk); #1;
      hc_done = 1'b0;
    end else begin
      e.done_cyc = n_cyc + 2 + TIMEOUT;
      sb.push_back(e);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rx_ready_timeout_wait", rx_ready, 0);
    end
    @(negedge clk);
    wait_done();
  endtask

  initial begin
    int c;
    vec_t vb;
    reset       = 1'b1;
    rx_data     = '0;
    rx_valid    = 1'b0;
    rx_bytenum  = '0;
    hc_hashcode = '0;
    hc_done     = 1'b0;
    for (int i = 0; i < 64; i++) base_msg[511 - 8*i -: 8] = 8'(i + 1);
    for (int i = 0; i < 50; i++) hv[32*i +: 32] = $urandom;

    //           msg        flip  gap bn    dly match err
    vecs[0] = '{base_msg,   -1,   0, 3'd7,  1, 1'b1, 1'b0};
    vecs[1] = '{base_msg,    0,   0, 3'd7,  1, 1'b0, 1'b0};
    vecs[2] = '{base_msg,   -1,   1, 3'd5,  3, 1'b1, 1'b0};
    vecs[3] = '{~base_msg, 1599,  2, 3'd1,  5, 1'b0, 1'b0};
    vecs[4] = '{~base_msg,  -1,   0, 3'd0, 10, 1'b1, 1'b0};
    vecs[5] = '{base_msg,   -1,   0, 3'd2, -1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_hc_in_ready", hc_in_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_match", match, 0);
    chk("reset_err", err, 0);
    chk("reset_hc_msg", hc_msg, 0);
    chk("reset_hc_bytenum", hc_bytenum, 0);
    chk("reset_msg_out", msg_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_reset", rx_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset after word 20: the partial frame must vanish without a done pulse.
    send_words({~base_msg, ~hv}, 21, 0, 3'd4, c);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("midframe_reset_rx_ready", rx_ready, 0);
    chk("midframe_reset_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    vb = '{base_msg ^ {16{32'h0f0f_1234}}, -1, 0, 3'd6, 2, 1'b1, 1'b0};
    run_vec(vb);

    // Reset while waiting on the engine, then a late hc_done that must be ignored.
    send_words({base_msg, hv}, 33, 0, 3'd3, c);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("wait_reset_done", done, 0);
    chk("wait_reset_match", match, 0);
    chk("wait_reset_msg_out", msg_out, 0);
    chk("wait_reset_hc_msg", hc_msg, 0);
    @(posedge clk); #1;
    reset       = 1'b0;
    hc_hashcode = hv;
    hc_done     = 1'b1;
    @(posedge clk); #1;
    hc_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_hc_done_ignored_ready", rx_ready, 1);
    chk("late_hc_done_no_start", hc_in_ready, 0);
    @(posedge clk); #1;
    run_vec(vecs[1]);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
